bitplane_rle_encoder: RTL and testbench

Run-length encoder placed directly downstream of `readImage`. Takes the 200-bit bit-plane words that `readImage` emits on `b1` and scans each bit-plane serially, LSB first. Emits alternating zero/one run lengths as fixed-width tokens on a valid/ready stream for the packing/transmit stage. Processes one complete plane per `start`.

---
 rtl/bitplane_rle_pkg.sv | 24 ++
 rtl/bitplane_rle_encoder.sv | 155 +++++++++++++++
 tb/tb_bitplane_rle_encoder.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitplane_rle_pkg.sv
// Shared types and default sizes for the bit-plane run-length encoder.
package bitplane_rle_pkg;

    localparam int DEF_WORD_W          = 200;
    localparam int DEF_WORDS_PER_PLANE = 5;
    localparam int DEF_RUN_W           = 8;

    // Encoder control states.
    typedef enum logic [2:0] {
        IDLE,
        WAIT_WORD,
        SCAN,
        EMIT,
        EMIT_ZERO,
        FINAL
    } state_t;

    // Why the scanner stopped: the bit value changed, or the run counter filled up.
    typedef enum logic {
        FLIP,
        SAT
    } reason_t;

endpackage

// File: rtl/bitplane_rle_encoder.sv
// Serial run-length encoder for one bit-plane per start pulse.
// Bits are consumed LSB first; runs alternate starting with zeros and are
// emitted as RUN_W-bit tokens. A run that fills the counter is split by a
// zero-length token so the decoder stays in phase.
module bitplane_rle_encoder
    import bitplane_rle_pkg::*;
#(
    parameter int WORD_W          = DEF_WORD_W,
    parameter int WORDS_PER_PLANE = DEF_WORDS_PER_PLANE,
    parameter int RUN_W           = DEF_RUN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [RUN_W-1:0]  out_run,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int WCNT_W = (WORDS_PER_PLANE > 1) ? $clog2(WORDS_PER_PLANE) : 1;

    localparam logic [RUN_W-1:0]  RUN_MAX   = {RUN_W{1'b1}};
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_PLANE - 1);

    state_t             state;
    state_t             state_next;
    reason_t            reason;
    logic [WORD_W-1:0]  shreg;
    logic [RUN_W-1:0]   count;
    logic [BIT_W-1:0]   bitidx;
    logic [WCNT_W-1:0]  words;
    logic               cur;
    logic               scan_bit;
    logic               scan_flip;
    logic               scan_sat;

    assign scan_bit  = shreg[0];
    assign scan_flip = (scan_bit != cur);
    assign scan_sat  = (scan_bit == cur) && (count == RUN_MAX);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and output decode; outputs depend only on registered state.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_run    = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_next = WAIT_WORD;
            end
            WAIT_WORD: begin
                in_ready = 1'b1;
                if (in_valid) state_next = SCAN;
            end
            SCAN: begin
                if (scan_flip || scan_sat)
                    state_next = EMIT;
                else if (bitidx == LAST_BIT)
                    state_next = (words == LAST_WORD) ? FINAL : WAIT_WORD;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_run   = count;
                if (out_ready) state_next = (reason == SAT) ? EMIT_ZERO : SCAN;
            end
            EMIT_ZERO: begin
                out_valid = 1'b1;
                if (out_ready) state_next = SCAN;
            end
            FINAL: begin
                out_valid = 1'b1;
                out_run   = count;
                out_last  = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Run counter, current run value, word/bit indices, stop reason and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            cur    <= 1'b0;
            words  <= '0;
            bitidx <= '0;
            reason <= FLIP;
            done   <= 1'b0;
        end else begin
            done <= (state == FINAL) && out_ready;
            case (state)
                IDLE: begin
                    if (start) begin
                        count <= '0;
                        cur   <= 1'b0;
                        words <= '0;
                    end
                end
                WAIT_WORD: begin
                    if (in_valid) bitidx <= '0;
                end
                SCAN: begin
                    if (scan_flip) begin
                        reason <= FLIP;
                    end else if (scan_sat) begin
                        reason <= SAT;
                    end else begin
                        count  <= count + 1'b1;
                        bitidx <= bitidx + 1'b1;
                        if (bitidx == LAST_BIT && words != LAST_WORD)
                            words <= words + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready && reason == FLIP) begin
                        count <= '0;
                        cur   <= ~cur;
                    end
                end
                EMIT_ZERO: begin
                    if (out_ready) count <= '0;
                end
                default: ;
            endcase
        end
    end

    // Plane shift register: loaded per word, shifted right as bits are consumed.
    always_ff @(posedge clk) begin
        // NOTE: pure datapath storage is left unreset; it is always loaded before it is read.
        if (state == WAIT_WORD && in_valid)
            shreg <= in_data;
        else if (state == SCAN && !scan_flip && !scan_sat)
            shreg <= shreg >> 1;
    end

endmodule

// File: tb/tb_bitplane_rle_encoder.sv
// Directed bench for bitplane_rle_encoder: one-word and two-word planes,
// alternating bits, backpressure, mid-plane reset and ignored start pulses.
module tb_bitplane_rle_encoder;

    localparam int W = 200;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_a, start_b;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready_a, out_valid_a, out_last_a, busy_a, done_a;
    logic [7:0]   out_run_a;
    logic         in_ready_b, out_valid_b, out_last_b, busy_b, done_b;
    logic [7:0]   out_run_b;

    // Selected-instance view: 0 = one-word plane, 1 = two-word plane.
    bit           sel;
    logic         m_in_ready, m_valid, m_last, m_busy, m_done;
    logic [7:0]   m_run;

    int           nchk  = 0;
    int           nfail = 0;

    int           toks[$];
    bit           lasts[$];
    int           latency;
    bit           timed_out;
    bit           done_seen, done_after, busy_after;
    int           stall_bad, stall_cycles;

    always #5 clk = ~clk;

    bitplane_rle_encoder #(.WORD_W(W), .WORDS_PER_PLANE(1), .RUN_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .out_run(out_run_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_last(out_last_a), .busy(busy_a), .done(done_a)
    );

    bitplane_rle_encoder #(.WORD_W(W), .WORDS_PER_PLANE(2), .RUN_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .out_run(out_run_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_last(out_last_b), .busy(busy_b), .done(done_b)
    );

    always_comb begin
        m_in_ready = sel ? in_ready_b  : in_ready_a;
        m_valid    = sel ? out_valid_b : out_valid_a;
        m_last     = sel ? out_last_b  : out_last_a;
        m_busy     = sel ? busy_b      : busy_a;
        m_done     = sel ? done_b      : done_a;
        m_run      = sel ? out_run_b   : out_run_a;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input bit v);
        start_a = v && !sel;
        start_b = v && sel;
    endtask

    // Runs one plane on the selected instance and records tokens and timing.
    task automatic run_plane(input logic [W-1:0] w0, input logic [W-1:0] w1, input int nwords,
                             input int stall_tok, input int stall_len, input bit poke);
        int         wi;
        int         cyc;
        bit         fin;
        bit         acc;
        logic [7:0] hold_run;
        logic       hold_last;
        toks.delete();
        lasts.delete();
        stall_bad    = 0;
        stall_cycles = 0;
        wi  = 0;
        cyc = 0;
        fin = 1'b0;
        hold_run  = '0;
        hold_last = 1'b0;
        set_start(1'b1);
        step();
        set_start(1'b0);
        while (!fin && cyc < 4000) begin
            in_data   = (wi == 0) ? w0 : w1;
            in_valid  = (wi < nwords);
            out_ready = 1'b1;
            if (m_valid && toks.size() == stall_tok && stall_cycles < stall_len) begin
                out_ready = 1'b0;
                if (stall_cycles == 0) begin
                    hold_run  = m_run;
                    hold_last = m_last;
                end
                if (m_run !== hold_run || m_last !== hold_last || m_in_ready !== 1'b0)
                    stall_bad++;
                stall_cycles++;
            end
            set_start(poke && (cyc % 7 == 3));
            acc = m_in_ready && in_valid;
            if (m_valid && out_ready) begin
                toks.push_back(int'(m_run));
                lasts.push_back(m_last);
                if (m_last) fin = 1'b1;
            end
            step();
            cyc++;
            if (acc) wi++;
        end
        set_start(1'b0);
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        timed_out  = !fin;
        latency    = cyc;
        done_seen  = m_done;
        busy_after = m_busy;
        step();
        done_after = m_done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_start(1'b0);
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        step();
        step();
        nchk++;
        if ({in_ready_a, out_valid_a, out_last_a, busy_a, done_a, out_run_a} !== 13'b0) begin
            nfail++;
            $display("FAIL reset_outputs_a: got %b, want all zero",
                     {in_ready_a, out_valid_a, out_last_a, busy_a, done_a, out_run_a});
        end
        nchk++;
        if ({in_ready_b, out_valid_b, out_last_b, busy_b, done_b, out_run_b} !== 13'b0) begin
            nfail++;
            $display("FAIL reset_outputs_b: got %b, want all zero",
                     {in_ready_b, out_valid_b, out_last_b, busy_b, done_b, out_run_b});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_zeros();
        int exp[$];
        sel = 1'b0;
        exp = '{200};
        run_plane('0, '0, 1, -1, 0, 1'b0);
        nchk++;
        if (timed_out) begin nfail++; $display("FAIL zeros_timeout: plane did not finish"); end
        nchk++;
        if (toks.size() != exp.size()) begin
            nfail++; $display("FAIL zeros_count: got %0d tokens, want %0d", toks.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            int g;
            bit gl;
            g  = (i < toks.size()) ? toks[i] : -1;
            gl = (i < lasts.size()) ? lasts[i] : 1'b0;
            nchk++;
            if (g !== exp[i] || gl !== (i == exp.size() - 1)) begin
                nfail++; $display("FAIL zeros_tok%0d: got %0d last=%0d, want %0d last=%0d",
                                  i, g, gl, exp[i], (i == exp.size() - 1));
            end
        end
        nchk++;
        if (latency !== 202) begin nfail++; $display("FAIL zeros_latency: got %0d, want 202", latency); end
        nchk++;
        if ({done_seen, done_after, busy_after} !== 3'b100) begin
            nfail++; $display("FAIL zeros_done: got done=%0d next=%0d busy=%0d, want 1 0 0",
                              done_seen, done_after, busy_after);
        end
    endtask

    task automatic test_ones();
        int exp[$];
        sel = 1'b0;
        exp = '{0, 200};
        run_plane('1, '0, 1, -1, 0, 1'b0);
        nchk++;
        if (timed_out) begin nfail++; $display("FAIL ones_timeout: plane did not finish"); end
        nchk++;
        if (toks.size() != exp.size()) begin
            nfail++; $display("FAIL ones_count: got %0d tokens, want %0d", toks.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            int g;
            bit gl;
            g  = (i < toks.size()) ? toks[i] : -1;
            gl = (i < lasts.size()) ? lasts[i] : 1'b0;
            nchk++;
            if (g !== exp[i] || gl !== (i == exp.size() - 1)) begin
                nfail++; $display("FAIL ones_tok%0d: got %0d last=%0d, want %0d last=%0d",
                                  i, g, gl, exp[i], (i == exp.size() - 1));
            end
        end
    endtask

    task automatic test_two_words();
        int exp[$];
        sel = 1'b1;
        exp = '{255, 0, 145};
        run_plane('0, '0, 2, -1, 0, 1'b0);
        nchk++;
        if (timed_out) begin nfail++; $display("FAIL two_words_timeout: plane did not finish"); end
        nchk++;
        if (toks.size() != exp.size()) begin
            nfail++; $display("FAIL two_words_count: got %0d tokens, want %0d", toks.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            int g;
            bit gl;
            g  = (i < toks.size()) ? toks[i] : -1;
            gl = (i < lasts.size()) ? lasts[i] : 1'b0;
            nchk++;
            if (g !== exp[i] || gl !== (i == exp.size() - 1)) begin
                nfail++; $display("FAIL two_words_tok%0d: got %0d last=%0d, want %0d last=%0d",
                                  i, g, gl, exp[i], (i == exp.size() - 1));
            end
        end
        nchk++;
        if (latency !== 406) begin nfail++; $display("FAIL two_words_latency: got %0d, want 406", latency); end
        nchk++;
        if (done_seen !== 1'b1 || done_after !== 1'b0) begin
            nfail++; $display("FAIL two_words_done: got %0d then %0d, want 1 then 0", done_seen, done_after);
        end
        sel = 1'b0;
    endtask

    task automatic test_alternating();
        logic [W-1:0] w;
        int           bad;
        sel = 1'b0;
        for (int i = 0; i < W; i++) w[i] = (i % 2 == 1);
        run_plane(w, '0, 1, -1, 0, 1'b0);
        nchk++;
        if (timed_out) begin nfail++; $display("FAIL alt_timeout: plane did not finish"); end
        nchk++;
        if (toks.size() != 200) begin
            nfail++; $display("FAIL alt_count: got %0d tokens, want 200", toks.size());
        end
        bad = 0;
        for (int i = 0; i < toks.size(); i++)
            if (toks[i] !== 1 || lasts[i] !== (i == 199)) bad++;
        nchk++;
        if (bad != 0) begin nfail++; $display("FAIL alt_tokens: got %0d bad tokens, want 0", bad); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w;
        int           exp[$];
        int           ref_toks[$];
        int           ref_lat;
        sel = 1'b0;
        for (int i = 0; i < W; i++) w[i] = ((i / 3) % 2 == 1);
        for (int i = 0; i < 66; i++) exp.push_back(3);
        exp.push_back(2);
        run_plane(w, '0, 1, -1, 0, 1'b0);
        ref_toks = toks;
        ref_lat  = latency;
        run_plane(w, '0, 1, 1, 10, 1'b0);
        nchk++;
        if (timed_out) begin nfail++; $display("FAIL bp_timeout: plane did not finish"); end
        nchk++;
        if (toks.size() != exp.size()) begin
            nfail++; $display("FAIL bp_count: got %0d tokens, want %0d", toks.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            int g;
            bit gl;
            g  = (i < toks.size()) ? toks[i] : -1;
            gl = (i < lasts.size()) ? lasts[i] : 1'b0;
            nchk++;
            if (g !== exp[i] || gl !== (i == exp.size() - 1)) begin
                nfail++; $display("FAIL bp_tok%0d: got %0d last=%0d, want %0d last=%0d",
                                  i, g, gl, exp[i], (i == exp.size() - 1));
            end
        end
        nchk++;
        if (toks != ref_toks) begin nfail++; $display("FAIL bp_vs_nostall: token streams differ"); end
        nchk++;
        if (stall_cycles !== 10 || stall_bad !== 0) begin
            nfail++; $display("FAIL bp_stall: got %0d stall cycles with %0d unstable, want 10 and 0",
                              stall_cycles, stall_bad);
        end
        nchk++;
        if (latency !== ref_lat + 10) begin
            nfail++; $display("FAIL bp_latency: got %0d, want %0d", latency, ref_lat + 10);
        end
    endtask

    task automatic test_reset_mid();
        int exp[$];
        sel = 1'b0;
        exp = '{200};
        set_start(1'b1);
        step();
        set_start(1'b0);
        in_data  = '0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        nchk++;
        if ({in_ready_a, out_valid_a, out_last_a, busy_a, done_a, out_run_a} !== 13'b0) begin
            nfail++; $display("FAIL reset_mid_outputs: got %b, want all zero",
                              {in_ready_a, out_valid_a, out_last_a, busy_a, done_a, out_run_a});
        end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        nchk++;
        if (busy_a !== 1'b0 || in_ready_a !== 1'b0) begin
            nfail++; $display("FAIL reset_mid_idle: got busy=%0d in_ready=%0d, want 0 0", busy_a, in_ready_a);
        end
        run_plane('0, '0, 1, -1, 0, 1'b0);
        nchk++;
        if (timed_out || toks.size() != 1) begin
            nfail++; $display("FAIL reset_mid_count: got %0d tokens timeout=%0d, want 1 and 0", toks.size(), timed_out);
        end
        nchk++;
        if (toks.size() > 0 && (toks[0] !== exp[0] || lasts[0] !== 1'b1)) begin
            nfail++; $display("FAIL reset_mid_tok: got %0d last=%0d, want 200 last=1", toks[0], lasts[0]);
        end
    endtask

    task automatic test_start_ignored();
        sel = 1'b0;
        run_plane('0, '0, 1, -1, 0, 1'b1);
        nchk++;
        if (timed_out || toks.size() != 1 || toks[0] !== 200 || lasts[0] !== 1'b1) begin
            nfail++; $display("FAIL start_ignored_zeros: got %0d tokens first=%0d, want 1 token 200",
                              toks.size(), (toks.size() > 0) ? toks[0] : -1);
        end
        nchk++;
        if (latency !== 202) begin nfail++; $display("FAIL start_ignored_latency: got %0d, want 202", latency); end
        run_plane('1, '0, 1, -1, 0, 1'b1);
        nchk++;
        if (timed_out || toks.size() != 2 || toks[0] !== 0 || toks[1] !== 200 || lasts[1] !== 1'b1) begin
            nfail++; $display("FAIL start_ignored_ones: got %0d tokens last=%0d, want 0,200",
                              toks.size(), (toks.size() > 0) ? toks[toks.size() - 1] : -1);
        end
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_zeros();
        test_ones();
        test_two_words();
        test_alternating();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
